// File: rtl/playseq_unidade_controle.sv
// PlaySeq control unit: Moore FSM sequencing the playseq_fluxo_dados datapath
// (LED preview, player input with timeout, compare, append, win/loss metrics).
// Optional build macro PLAYSEQ_DB_ESTADO_EN adds the db_estado debug port.
module playseq_unidade_controle #(
    parameter int W_ESTADO = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic iniciar,
    input  logic igual,
    input  logic fimE,
    input  logic tem_jogada,
    input  logic controle_timeout,
    input  logic controle_timeout_led,
    input  logic enderecoIgualSequencia,
    input  logic pare,
    input  logic vai_escrever,
    output logic zeraE,
    output logic contaE,
    output logic zeraS,
    output logic carregaS,
    output logic contaS,
    output logic zeraR,
    output logic registraR,
    output logic zeraT,
    output logic contaT,
    output logic zeraT_leds,
    output logic contaT_leds,
    output logic controla_leds,
    output logic fase_preview,
    output logic ram_escreve,
    output logic zeraJ,
    output logic contaJ,
    output logic conta_ganhar,
    output logic conta_perder,
    output logic zera_metricas,
    output logic pronto
`ifdef PLAYSEQ_DB_ESTADO_EN
    ,
    output logic [W_ESTADO-1:0] db_estado
`endif
);

    typedef enum logic [W_ESTADO-1:0] {
        INICIAL       = 0,
        ZERA_SESSAO   = 1,
        PREPARA       = 2,
        MOSTRA        = 3,
        PAUSA_LED     = 4,
        APAGA         = 5,
        PROX_LED      = 6,
        FIM_PREVIEW   = 7,
        ESPERA_JOGADA = 8,
        REGISTRA      = 9,
        COMPARA       = 10,
        ESCREVE       = 11,
        PROX_JOGADA   = 12,
        PROX_SEQ      = 13,
        GANHOU        = 14,
        PERDEU        = 15,
        FIM_ACERTOU   = 16,
        FIM_ERROU     = 17,
        FIM_TIMEOUT   = 18,
        ESGOTOU       = 19
    } estado_t;

    estado_t estado, proximo;

    // State register with synchronous reset to INICIAL
    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    // Next-state decode; unused codes fall back to INICIAL
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:       if (iniciar) proximo = ZERA_SESSAO;
            ZERA_SESSAO:   proximo = PREPARA;
            PREPARA:       proximo = MOSTRA;
            MOSTRA:        if (controle_timeout_led) proximo = PAUSA_LED;
            PAUSA_LED:     proximo = APAGA;
            APAGA:
                if (controle_timeout_led)
                    proximo = enderecoIgualSequencia ? FIM_PREVIEW : PROX_LED;
            PROX_LED:      proximo = MOSTRA;
            FIM_PREVIEW:   proximo = ESPERA_JOGADA;
            // a player move takes priority over a simultaneous timeout
            ESPERA_JOGADA:
                if (tem_jogada)            proximo = REGISTRA;
                else if (controle_timeout) proximo = ESGOTOU;
            REGISTRA:
                proximo = (vai_escrever && enderecoIgualSequencia) ? ESCREVE : COMPARA;
            COMPARA:
                if (!igual)                       proximo = PERDEU;
                else if (!enderecoIgualSequencia) proximo = PROX_JOGADA;
                else if (fimE)                    proximo = GANHOU;
                else                              proximo = PROX_SEQ;
            ESCREVE:       proximo = fimE ? GANHOU : PROX_SEQ;
            PROX_JOGADA:   proximo = ESPERA_JOGADA;
            PROX_SEQ:      proximo = MOSTRA;
            GANHOU:        proximo = FIM_ACERTOU;
            PERDEU:        proximo = FIM_ERROU;
            ESGOTOU:       proximo = FIM_TIMEOUT;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                if (iniciar) proximo = pare ? ZERA_SESSAO : PREPARA;
            default:       proximo = INICIAL;
        endcase
    end

    // Moore output decode: every strobe is a pure function of the state
    always_comb begin
        zeraE = 1'b0; contaE = 1'b0; zeraS = 1'b0; carregaS = 1'b0; contaS = 1'b0;
        zeraR = 1'b0; registraR = 1'b0; zeraT = 1'b0; contaT = 1'b0;
        zeraT_leds = 1'b0; contaT_leds = 1'b0; controla_leds = 1'b0; fase_preview = 1'b0;
        ram_escreve = 1'b0; zeraJ = 1'b0; contaJ = 1'b0; conta_ganhar = 1'b0;
        conta_perder = 1'b0; zera_metricas = 1'b0; pronto = 1'b0;
        case (estado)
            ZERA_SESSAO:   begin zeraJ = 1'b1; zera_metricas = 1'b1; end
            PREPARA:       begin zeraE = 1'b1; zeraR = 1'b1; carregaS = 1'b1;
                                 zeraT = 1'b1; zeraT_leds = 1'b1; end
            MOSTRA:        begin fase_preview = 1'b1; controla_leds = 1'b1; contaT_leds = 1'b1; end
            PAUSA_LED:     begin fase_preview = 1'b1; zeraT_leds = 1'b1; end
            APAGA:         begin fase_preview = 1'b1; contaT_leds = 1'b1; end
            PROX_LED:      begin fase_preview = 1'b1; contaE = 1'b1; zeraT_leds = 1'b1; end
            FIM_PREVIEW:   begin zeraE = 1'b1; zeraT = 1'b1; end
            ESPERA_JOGADA: contaT = 1'b1;
            REGISTRA:      registraR = 1'b1;
            ESCREVE:       ram_escreve = 1'b1;
            PROX_JOGADA:   begin contaE = 1'b1; zeraT = 1'b1; end
            PROX_SEQ:      begin contaS = 1'b1; zeraE = 1'b1; zeraT = 1'b1; zeraT_leds = 1'b1; end
            GANHOU:        begin conta_ganhar = 1'b1; contaJ = 1'b1; end
            PERDEU, ESGOTOU: begin conta_perder = 1'b1; contaJ = 1'b1; end
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: pronto = 1'b1;
            default: ;
        endcase
    end

`ifdef PLAYSEQ_DB_ESTADO_EN
    assign db_estado = estado;
`endif

endmodule

// File: tb/tb_playseq_unidade_controle.sv
// Scoreboard bench for playseq_unidade_controle: random stimulus, table-driven
// reference of the game flow, monitor compares every presented output cycle.
module tb_playseq_unidade_controle;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, iniciar, igual, fimE, tem_jogada, controle_timeout, controle_timeout_led;
    logic enderecoIgualSequencia, pare, vai_escrever;
    logic zeraE, contaE, zeraS, carregaS, contaS, zeraR, registraR, zeraT, contaT;
    logic zeraT_leds, contaT_leds, controla_leds, fase_preview, ram_escreve;
    logic zeraJ, contaJ, conta_ganhar, conta_perder, zera_metricas, pronto;
`ifdef PLAYSEQ_DB_ESTADO_EN
    logic [4:0] db_estado;
`endif

    playseq_unidade_controle #(.W_ESTADO(5)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual), .fimE(fimE),
        .tem_jogada(tem_jogada), .controle_timeout(controle_timeout),
        .controle_timeout_led(controle_timeout_led),
        .enderecoIgualSequencia(enderecoIgualSequencia), .pare(pare), .vai_escrever(vai_escrever),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .carregaS(carregaS), .contaS(contaS),
        .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
        .zeraT_leds(zeraT_leds), .contaT_leds(contaT_leds), .controla_leds(controla_leds),
        .fase_preview(fase_preview), .ram_escreve(ram_escreve), .zeraJ(zeraJ), .contaJ(contaJ),
        .conta_ganhar(conta_ganhar), .conta_perder(conta_perder),
        .zera_metricas(zera_metricas), .pronto(pronto)
`ifdef PLAYSEQ_DB_ESTADO_EN
        , .db_estado(db_estado)
`endif
    );

    // Bit positions of each strobe in the observed output word
    localparam int O_ZERAE = 19, O_CONTAE = 18, O_ZERAS = 17, O_CARREGAS = 16, O_CONTAS = 15;
    localparam int O_ZERAR = 14, O_REGISTRAR = 13, O_ZERAT = 12, O_CONTAT = 11;
    localparam int O_ZERAT_LEDS = 10, O_CONTAT_LEDS = 9, O_CONTROLA_LEDS = 8, O_FASE_PREVIEW = 7;
    localparam int O_RAM_ESCREVE = 6, O_ZERAJ = 5, O_CONTAJ = 4, O_CONTA_GANHAR = 3;
    localparam int O_CONTA_PERDER = 2, O_ZERA_METRICAS = 1, O_PRONTO = 0;

    logic [19:0] act;
    assign act = {zeraE, contaE, zeraS, carregaS, contaS, zeraR, registraR, zeraT, contaT,
                  zeraT_leds, contaT_leds, controla_leds, fase_preview, ram_escreve,
                  zeraJ, contaJ, conta_ganhar, conta_perder, zera_metricas, pronto};

    typedef struct {
        logic [19:0] outs;
        int          code;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Game phases, numbered with the documented state codes
    localparam int P_IDLE = 'h00, P_NEW_SESSION = 'h01, P_PREP = 'h02, P_SHOW = 'h03;
    localparam int P_LED_GAP = 'h04, P_DARK = 'h05, P_NEXT_LED = 'h06, P_END_PREVIEW = 'h07;
    localparam int P_WAIT = 'h08, P_LATCH = 'h09, P_CMP = 'h0A, P_WRITE = 'h0B;
    localparam int P_NEXT_MOVE = 'h0C, P_NEXT_ROUND = 'h0D, P_WIN = 'h0E, P_LOSE = 'h0F;
    localparam int P_END_WIN = 'h10, P_END_LOSE = 'h11, P_END_TIMEOUT = 'h12, P_TIMEOUT = 'h13;

    function automatic logic [19:0] strobes_of(input int p);
        logic [19:0] m;
        m = '0;
        case (p)
            P_NEW_SESSION: begin m[O_ZERAJ] = 1; m[O_ZERA_METRICAS] = 1; end
            P_PREP: begin m[O_ZERAE] = 1; m[O_ZERAR] = 1; m[O_CARREGAS] = 1;
                          m[O_ZERAT] = 1; m[O_ZERAT_LEDS] = 1; end
            P_SHOW: begin m[O_FASE_PREVIEW] = 1; m[O_CONTROLA_LEDS] = 1; m[O_CONTAT_LEDS] = 1; end
            P_LED_GAP: begin m[O_FASE_PREVIEW] = 1; m[O_ZERAT_LEDS] = 1; end
            P_DARK: begin m[O_FASE_PREVIEW] = 1; m[O_CONTAT_LEDS] = 1; end
            P_NEXT_LED: begin m[O_FASE_PREVIEW] = 1; m[O_CONTAE] = 1; m[O_ZERAT_LEDS] = 1; end
            P_END_PREVIEW: begin m[O_ZERAE] = 1; m[O_ZERAT] = 1; end
            P_WAIT: m[O_CONTAT] = 1;
            P_LATCH: m[O_REGISTRAR] = 1;
            P_WRITE: m[O_RAM_ESCREVE] = 1;
            P_NEXT_MOVE: begin m[O_CONTAE] = 1; m[O_ZERAT] = 1; end
            P_NEXT_ROUND: begin m[O_CONTAS] = 1; m[O_ZERAE] = 1; m[O_ZERAT] = 1;
                                m[O_ZERAT_LEDS] = 1; end
            P_WIN: begin m[O_CONTA_GANHAR] = 1; m[O_CONTAJ] = 1; end
            P_LOSE, P_TIMEOUT: begin m[O_CONTA_PERDER] = 1; m[O_CONTAJ] = 1; end
            P_END_WIN, P_END_LOSE, P_END_TIMEOUT: m[O_PRONTO] = 1;
            default: ;
        endcase
        return m;
    endfunction

    // Reference game flow: where the controller goes after one clock
    function automatic int advance(input int p);
        if (reset) return P_IDLE;
        case (p)
            P_IDLE:        return iniciar ? P_NEW_SESSION : P_IDLE;
            P_NEW_SESSION: return P_PREP;
            P_PREP:        return P_SHOW;
            P_SHOW:        return controle_timeout_led ? P_LED_GAP : P_SHOW;
            P_LED_GAP:     return P_DARK;
            P_DARK: begin
                if (!controle_timeout_led) return P_DARK;
                return enderecoIgualSequencia ? P_END_PREVIEW : P_NEXT_LED;
            end
            P_NEXT_LED:    return P_SHOW;
            P_END_PREVIEW: return P_WAIT;
            P_WAIT: begin
                if (tem_jogada) return P_LATCH;
                if (controle_timeout) return P_TIMEOUT;
                return P_WAIT;
            end
            P_LATCH:       return (vai_escrever && enderecoIgualSequencia) ? P_WRITE : P_CMP;
            P_CMP: begin
                if (!igual) return P_LOSE;
                if (!enderecoIgualSequencia) return P_NEXT_MOVE;
                return fimE ? P_WIN : P_NEXT_ROUND;
            end
            P_WRITE:       return fimE ? P_WIN : P_NEXT_ROUND;
            P_NEXT_MOVE:   return P_WAIT;
            P_NEXT_ROUND:  return P_SHOW;
            P_WIN:         return P_END_WIN;
            P_LOSE:        return P_END_LOSE;
            P_TIMEOUT:     return P_END_TIMEOUT;
            P_END_WIN, P_END_LOSE, P_END_TIMEOUT: begin
                if (!iniciar) return p;
                return pare ? P_NEW_SESSION : P_PREP;
            end
            default:       return P_IDLE;
        endcase
    endfunction

    // Monitor: the DUT presents a fresh Moore output word after every clock edge
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (act !== e.outs) begin
                bad++;
                $display("FAIL strobes t=%0t phase=%02h actual=%05h required=%05h",
                         $time, e.code, act, e.outs);
            end
`ifdef PLAYSEQ_DB_ESTADO_EN
            total++;
            if (db_estado !== 5'(e.code)) begin
                bad++;
                $display("FAIL db_estado t=%0t actual=%02h required=%02h",
                         $time, db_estado, e.code);
            end
`endif
        end
    end

    int phase = P_IDLE;

    task automatic drive_random();
        reset                  = ($urandom_range(0, 249) == 0);
        iniciar                = ($urandom_range(0, 2) == 0);
        pare                   = ($urandom_range(0, 2) == 0);
        igual                  = ($urandom_range(0, 4) != 0);
        fimE                   = ($urandom_range(0, 2) == 0);
        tem_jogada             = ($urandom_range(0, 2) == 0);
        controle_timeout       = ($urandom_range(0, 4) == 0);
        controle_timeout_led   = ($urandom_range(0, 2) == 0);
        enderecoIgualSequencia = ($urandom_range(0, 2) == 0);
        vai_escrever           = ($urandom_range(0, 1) == 0);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; pare = 1'b0; igual = 1'b0; fimE = 1'b0;
        tem_jogada = 1'b0; controle_timeout = 1'b0; controle_timeout_led = 1'b0;
        enderecoIgualSequencia = 1'b0; vai_escrever = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c < 3) begin
                reset = 1'b1;
            end else if (c < 13) begin
                reset = 1'b0;
                iniciar = 1'b0;
            end else begin
                drive_random();
            end
            phase = advance(phase);
            sb.push_back('{outs: strobes_of(phase), code: phase});
        end
        for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clock);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
